// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Mini SRC bus datapath: fetch T0-T2, execute T3-T7.
// Optional CTRL_MULDIV_EN adds mul/div sequencing; otherwise opcodes 14/15 act as nop.
module control_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR,
   input  logic        stp,
   output logic        Run,
   output logic        clr,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        Read,
   output logic        Write,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        ZLowout,
   output logic        ZHighout,
   output logic        HIin,
   output logic        LOin,
   output logic        HIout,
   output logic        LOout,
   output logic        Cout,
   output logic        conIn,
   output logic        conOut,
   output logic        InPortout,
   output logic        outPortin,
   output logic        R15ctrl,
   output logic [3:0]  ALUselect
);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3,
      S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_SHR  = 5'd5;
   localparam logic [4:0] OP_SHL  = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8;
   localparam logic [4:0] OP_AND  = 5'd9,  OP_OR   = 5'd10, OP_ADDI = 5'd11;
   localparam logic [4:0] OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_MUL  = 5'd14;
   localparam logic [4:0] OP_DIV  = 5'd15, OP_NEG  = 5'd16, OP_NOT  = 5'd17;
   localparam logic [4:0] OP_BR   = 5'd18, OP_JR   = 5'd19, OP_JAL  = 5'd20;
   localparam logic [4:0] OP_IN   = 5'd21, OP_OUT  = 5'd22, OP_MFHI = 5'd23;
   localparam logic [4:0] OP_MFLO = 5'd24, OP_HALT = 5'd26;

   state_t     state, nxt, last_st;
   logic [4:0] op;
   logic [3:0] alu_op;
   logic       unused_ir;

   assign op        = IR[31:27];
   assign unused_ir = ^IR[26:0];

   // Final execute step of the current opcode; T2 means fetch-only
   always_comb begin
      last_st = S_T2;
      case (op)
         OP_LD, OP_ST: last_st = S_T7;
         OP_LDI, OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
         OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: last_st = S_T5;
         OP_NEG, OP_NOT, OP_JAL: last_st = S_T4;
         OP_BR: last_st = S_T6;
         OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: last_st = S_T3;
`ifdef CTRL_MULDIV_EN
         OP_MUL, OP_DIV: last_st = S_T6;
`endif
         default: last_st = S_T2;
      endcase
   end

   always_comb begin
      alu_op = 4'b0000;
      case (op)
         OP_LD, OP_LDI, OP_ST,
         OP_ADD, OP_ADDI: alu_op = 4'b0001;
         OP_SUB:          alu_op = 4'b0010;
         OP_MUL:          alu_op = 4'b0011;
         OP_DIV:          alu_op = 4'b0100;
         OP_SHR:          alu_op = 4'b0101;
         OP_AND, OP_ANDI: alu_op = 4'b0110;
         OP_OR, OP_ORI:   alu_op = 4'b0111;
         OP_SHL:          alu_op = 4'b1000;
         OP_ROR:          alu_op = 4'b1010;
         OP_ROL:          alu_op = 4'b1011;
         OP_NEG:          alu_op = 4'b1100;
         OP_NOT:          alu_op = 4'b1101;
         default:         alu_op = 4'b0000;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_RESET;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         S_RESET: nxt = S_T0;
         S_T0:    nxt = S_T1;
         S_T1:    nxt = S_T2;
         S_HALT:  nxt = S_HALT;
         default: begin
            if (state == S_T2 && op == OP_HALT)
               nxt = S_HALT;
            else if (state >= last_st)
               nxt = stp ? S_HALT : S_T0;
            else
               nxt = state_t'(state + 4'd1);
         end
      endcase
   end

   always_comb begin
      Run = 1'b0; clr = 1'b0;
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
      Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
      PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
      MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
      Read = 1'b0; Write = 1'b0; IRin = 1'b0;
      Yin = 1'b0; Zin = 1'b0;
      ZLowout = 1'b0; ZHighout = 1'b0;
      HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0;
      Cout = 1'b0; conIn = 1'b0; conOut = 1'b0;
      InPortout = 1'b0; outPortin = 1'b0; R15ctrl = 1'b0;
      ALUselect = 4'b0000;
      case (state)
         S_RESET: clr = 1'b1;
         S_T0: begin
            Run = 1'b1; PCout = 1'b1; MARin = 1'b1;
            IncPC = 1'b1; Zin = 1'b1; ALUselect = 4'b1001;
         end
         S_T1: begin
            Run = 1'b1; ZLowout = 1'b1; PCin = 1'b1;
            Read = 1'b1; MDRin = 1'b1;
         end
         S_T2: begin
            Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
         end
         S_T3: begin
            Run = 1'b1;
            case (op)
               OP_LD, OP_LDI, OP_ST: begin
                  Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
               end
               OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
               OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                  Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
               end
               OP_NEG, OP_NOT: begin
                  Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUselect = alu_op;
               end
               OP_BR:   begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
               OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
               OP_JAL:  begin R15ctrl = 1'b1; PCout = 1'b1; end
               OP_IN:   begin Gra = 1'b1; Rin = 1'b1; InPortout = 1'b1; end
               OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; outPortin = 1'b1; end
               OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
`ifdef CTRL_MULDIV_EN
               OP_MUL, OP_DIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
`endif
               default: ;
            endcase
         end
         S_T4: begin
            Run = 1'b1;
            case (op)
               OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI: begin
                  Cout = 1'b1; Zin = 1'b1; ALUselect = alu_op;
               end
               OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
               OP_AND, OP_OR: begin
                  Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUselect = alu_op;
               end
               OP_NEG, OP_NOT: begin
                  ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end
               OP_BR:  begin PCout = 1'b1; Yin = 1'b1; end
               OP_JAL: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
`ifdef CTRL_MULDIV_EN
               OP_MUL, OP_DIV: begin
                  Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUselect = alu_op;
               end
`endif
               default: ;
            endcase
         end
         S_T5: begin
            Run = 1'b1;
            case (op)
               OP_LD, OP_ST: begin ZLowout = 1'b1; MARin = 1'b1; end
               OP_LDI, OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
               OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                  ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end
               OP_BR: begin
                  Cout = 1'b1; Zin = 1'b1; ALUselect = 4'b0001;
               end
`ifdef CTRL_MULDIV_EN
               OP_MUL, OP_DIV: begin ZLowout = 1'b1; LOin = 1'b1; end
`endif
               default: ;
            endcase
         end
         S_T6: begin
            Run = 1'b1;
            case (op)
               OP_LD: begin Read = 1'b1; MDRin = 1'b1; end
               OP_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
               OP_BR: begin ZLowout = 1'b1; conOut = 1'b1; end
`ifdef CTRL_MULDIV_EN
               OP_MUL, OP_DIV: begin ZHighout = 1'b1; HIin = 1'b1; end
`endif
               default: ;
            endcase
         end
         S_T7: begin
            Run = 1'b1;
            case (op)
               OP_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               OP_ST: begin MDRout = 1'b1; Write = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: packs every output into one word
// and compares each clock step against hand-built expected strobe sets.
module tb_control_unit;
   logic        clk, reset, stp;
   logic [31:0] IR;
   logic Run, clr, Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC;
   logic MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, ZLowout;
   logic ZHighout, HIin, LOin, HIout, LOout, Cout, conIn, conOut;
   logic InPortout, outPortin, R15ctrl;
   logic [3:0] ALUselect;
   logic [63:0] obs;
   int n_vec = 0;
   int n_err = 0;

   control_unit dut (
      .clk(clk), .reset(reset), .IR(IR), .stp(stp),
      .Run(Run), .clr(clr), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout), .PCout(PCout),
      .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin),
      .Yin(Yin), .Zin(Zin), .ZLowout(ZLowout), .ZHighout(ZHighout),
      .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
      .Cout(Cout), .conIn(conIn), .conOut(conOut),
      .InPortout(InPortout), .outPortin(outPortin),
      .R15ctrl(R15ctrl), .ALUselect(ALUselect)
   );

   localparam logic [63:0] RUN = 64'd1 << 0,  CLR = 64'd1 << 1;
   localparam logic [63:0] GRA = 64'd1 << 2,  GRB = 64'd1 << 3;
   localparam logic [63:0] GRC = 64'd1 << 4,  RIN = 64'd1 << 5;
   localparam logic [63:0] ROUT = 64'd1 << 6, BAOUT = 64'd1 << 7;
   localparam logic [63:0] PCOUT = 64'd1 << 8, PCIN = 64'd1 << 9;
   localparam logic [63:0] INCPC = 64'd1 << 10, MARIN = 64'd1 << 11;
   localparam logic [63:0] MDRIN = 64'd1 << 12, MDROUT = 64'd1 << 13;
   localparam logic [63:0] READ = 64'd1 << 14, WRITE = 64'd1 << 15;
   localparam logic [63:0] IRIN = 64'd1 << 16, YIN = 64'd1 << 17;
   localparam logic [63:0] ZIN = 64'd1 << 18, ZLOW = 64'd1 << 19;
   localparam logic [63:0] ZHIGH = 64'd1 << 20, HIIN = 64'd1 << 21;
   localparam logic [63:0] LOIN = 64'd1 << 22, HIOUT = 64'd1 << 23;
   localparam logic [63:0] LOOUT = 64'd1 << 24, COUT = 64'd1 << 25;
   localparam logic [63:0] CONIN = 64'd1 << 26, CONOUT = 64'd1 << 27;
   localparam logic [63:0] INPORT = 64'd1 << 28, OUTPORT = 64'd1 << 29;
   localparam logic [63:0] R15 = 64'd1 << 30;

   function automatic logic [63:0] alu(input logic [3:0] a);
      return 64'(a) << 31;
   endfunction

   always_comb
      obs = 64'({ALUselect, R15ctrl, outPortin, InPortout, conOut, conIn,
                 Cout, LOout, HIout, LOin, HIin, ZHighout, ZLowout, Zin,
                 Yin, IRin, Write, Read, MDRout, MDRin, MARin, IncPC,
                 PCin, PCout, BAout, Rout, Rin, Grc, Grb, Gra, clr, Run});

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic [63:0] exp);
      @(negedge clk);
      check(tag, obs, exp);
   endtask

   // IR is swapped after T0 so the previous instruction's last step saw its own IR
   task automatic fetch(input string tag, input logic [31:0] nir);
      step({tag, "_T0"}, RUN | PCOUT | MARIN | INCPC | ZIN | alu(4'b1001));
      IR = nir;
      step({tag, "_T1"}, RUN | ZLOW | PCIN | READ | MDRIN);
      step({tag, "_T2"}, RUN | MDROUT | IRIN);
   endtask

   task automatic pulse_reset(input string tag);
      reset = 1'b0;
      #1 check(tag, obs, CLR);
      #1 reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      stp   = 1'b0;
      IR    = 32'h0080_0055;
      @(negedge clk);
      check("reset", obs, CLR);
      reset = 1'b1;

      fetch("ld", 32'h0080_0055);
      step("ld_T3", RUN | GRB | BAOUT | YIN);
      step("ld_T4", RUN | COUT | ZIN | alu(4'b0001));
      step("ld_T5", RUN | ZLOW | MARIN);
      step("ld_T6", RUN | READ | MDRIN);
      step("ld_T7", RUN | MDROUT | GRA | RIN);

      fetch("addi", 32'h590F_FFFB);
      step("addi_T3", RUN | GRB | ROUT | YIN);
      step("addi_T4", RUN | COUT | ZIN | alu(4'b0001));
      step("addi_T5", RUN | ZLOW | GRA | RIN);

      fetch("br", 32'h9100_0023);
      step("br_T3", RUN | GRA | ROUT | CONIN);
      step("br_T4", RUN | PCOUT | YIN);
      step("br_T5", RUN | COUT | ZIN | alu(4'b0001));
      step("br_T6", RUN | ZLOW | CONOUT);

      fetch("jal", 32'hA080_0000);
      step("jal_T3", RUN | R15 | PCOUT);
      step("jal_T4", RUN | GRA | ROUT | PCIN);

      fetch("mul", 32'h7000_0000);
`ifdef CTRL_MULDIV_EN
      step("mul_T3", RUN | GRA | ROUT | YIN);
      step("mul_T4", RUN | GRB | ROUT | ZIN | alu(4'b0011));
      step("mul_T5", RUN | ZLOW | LOIN);
      step("mul_T6", RUN | ZHIGH | HIIN);
`endif

      fetch("in", 32'hA800_0000);
      step("in_T3", RUN | GRA | RIN | INPORT);

      fetch("mfhi", 32'hB800_0000);
      step("mfhi_T3", RUN | HIOUT | GRA | RIN);

      fetch("sub", 32'h2000_0000);
      step("sub_T3", RUN | GRB | ROUT | YIN);
      step("sub_T4", RUN | GRC | ROUT | ZIN | alu(4'b0010));
      step("sub_T5", RUN | ZLOW | GRA | RIN);
      stp = 1'b1;
      step("stp_halt", 64'd0);
      stp = 1'b0;
      step("halt_hold", 64'd0);

      pulse_reset("reset_from_halt");
      fetch("neg", 32'h8000_0000);
      step("neg_T3", RUN | GRB | ROUT | ZIN | alu(4'b1100));
      step("neg_T4", RUN | ZLOW | GRA | RIN);

      fetch("halt", 32'hD000_0000);
      step("halt_op", 64'd0);
      step("halt_op_hold", 64'd0);

      pulse_reset("reset_after_halt_op");
      fetch("ld2", 32'h0080_0055);
      step("ld2_T3", RUN | GRB | BAOUT | YIN);
      step("ld2_T4", RUN | COUT | ZIN | alu(4'b0001));
      pulse_reset("reset_mid_T4");
      step("post_reset_T0", RUN | PCOUT | MARIN | INCPC | ZIN | alu(4'b1001));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
